// File: rtl/mdbrot_pkg.sv
// ============================================================================
// Module   : mdbrot_pkg
// Brief    : Shared types and constants for the Mandelbrot pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mdbrot_pkg;

    // Q11.20 two's-complement, shared with the iteration core
    typedef logic signed [31:0] fixed_t;

    localparam int FRAC_BITS = 20;
    localparam int H_RES     = 160;
    localparam int V_RES     = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/mdbrot_pixel_scanner.sv
// ============================================================================
// Module   : mdbrot_pixel_scanner
// Brief    : Raster walker emitting (px, py, c_re, c_im) requests over valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdbrot_pixel_scanner #(
    parameter int H_RES = mdbrot_pkg::H_RES,
    parameter int V_RES = mdbrot_pkg::V_RES,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  mdbrot_pkg::fixed_t x0,
    input  mdbrot_pkg::fixed_t y0,
    input  mdbrot_pkg::fixed_t step,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XW-1:0]      out_px,
    output logic [YW-1:0]      out_py,
    output mdbrot_pkg::fixed_t out_cre,
    output mdbrot_pkg::fixed_t out_cim,
    output logic               busy,
    output logic               done
);

    import mdbrot_pkg::*;

    localparam logic [XW-1:0] c_PX_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] c_PY_LAST = YW'(V_RES - 1);

    scan_state_t   r_state;
    scan_state_t   w_next;
    fixed_t        r_x0;
    fixed_t        r_step;
    fixed_t        r_cre;
    fixed_t        r_cim;
    logic [XW-1:0] r_px;
    logic [YW-1:0] r_py;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_fire;
    logic          w_row_end;
    logic          w_frame_end;

    assign w_fire      = r_valid & out_ready;
    assign w_row_end   = (r_px == c_PX_LAST);
    assign w_frame_end = w_row_end && (r_py == c_PY_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (w_fire && w_frame_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_step  <= '0;
            r_cre   <= '0;
            r_cim   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_step  <= step;
                        r_cre   <= x0;
                        r_cim   <= y0;
                        r_px    <= '0;
                        r_py    <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_fire) begin
                        if (w_frame_end) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_row_end) begin
                            // New row restarts from the latched left edge; imaginary axis runs downward
                            r_px  <= '0;
                            r_cre <= r_x0;
                            r_py  <= r_py + YW'(1);
                            r_cim <= r_cim - r_step;
                        end else begin
                            r_px  <= r_px + XW'(1);
                            r_cre <= r_cre + r_step;
                        end
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_px    = r_px;
    assign out_py    = r_py;
    assign out_cre   = r_cre;
    assign out_cim   = r_cim;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mdbrot_pixel_scanner.sv
// ============================================================================
// Module   : tb_mdbrot_pixel_scanner
// Brief    : Scoreboard and vector-table bench for mdbrot_pixel_scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdbrot_pixel_scanner;

    localparam int NPIX = 160 * 120;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x0 = '0;
    logic [31:0] y0 = '0;
    logic [31:0] step = '0;
    logic        out_valid;
    logic [7:0]  out_px;
    logic [6:0]  out_py;
    logic [31:0] out_cre;
    logic [31:0] out_cim;
    logic        busy;
    logic        done;

    mdbrot_pixel_scanner #(
        .H_RES(160), .V_RES(120), .XW(8), .YW(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .step(step),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_px(out_px), .out_py(out_py),
        .out_cre(out_cre), .out_cim(out_cim),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          px;
        int          py;
        logic [31:0] cre;
        logic [31:0] cim;
    } pix_t;

    typedef struct {
        int          px;
        int          py;
        logic [31:0] cre;
        logic [31:0] cim;
    } vec_t;

    pix_t        q[$];
    vec_t        vt[6];
    logic [31:0] cap_cre [0:NPIX-1];
    logic [31:0] cap_cim [0:NPIX-1];
    logic [31:0] ref_cre [0:NPIX-1];
    logic [31:0] ref_cim [0:NPIX-1];

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int hs_cnt, sb_err, stall_err, done_cnt;
    int last_hs_cyc, done_cyc, busy_fall_cyc;
    logic        prev_stall = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  p_px;
    logic [6:0]  p_py;
    logic [31:0] p_cre, p_cim;

    int rdy_mode = 0;
    int rd_pct = 30;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        hs_cnt = 0; sb_err = 0; stall_err = 0; done_cnt = 0;
        last_hs_cyc = -1; done_cyc = -1; busy_fall_cyc = -1;
    endtask

    // Closed-form model: c = origin + index*step, independent of the DUT's accumulators
    task automatic push_frame(input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fs);
        pix_t e;
        for (int py = 0; py < 120; py++) begin
            for (int px = 0; px < 160; px++) begin
                e.px  = px;
                e.py  = py;
                e.cre = fx + 32'(px) * fs;
                e.cim = fy - 32'(py) * fs;
                q.push_back(e);
            end
        end
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_handshakes"}, 32'(hs_cnt), 32'(NPIX));
        check({tag, "_scoreboard_errs"}, 32'(sb_err), 32'd0);
        check({tag, "_stall_errs"}, 32'(stall_err), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_after_last_hs"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
        check({tag, "_busy_fall"}, 32'(busy_fall_cyc), 32'(done_cyc + 1));
    endtask

    task automatic apply_table(input string tag);
        int idx;
        for (int i = 0; i < 6; i++) begin
            idx = vt[i].py * 160 + vt[i].px;
            check($sformatf("%s_cre_%0d_%0d", tag, vt[i].px, vt[i].py), cap_cre[idx], vt[i].cre);
            check($sformatf("%s_cim_%0d_%0d", tag, vt[i].px, vt[i].py), cap_cim[idx], vt[i].cim);
        end
    endtask

    // Monitor: samples on the falling edge, a handshake seen here fires on the next rising edge
    always @(negedge clk) begin
        pix_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (prev_stall) begin
                if (!(out_valid && out_px == p_px && out_py == p_py &&
                      out_cre == p_cre && out_cim == p_cim))
                    stall_err++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    sb_err++;
                end else begin
                    e = q.pop_front();
                    if (e.px != int'(out_px) || e.py != int'(out_py) ||
                        e.cre != out_cre || e.cim != out_cim)
                        sb_err++;
                end
                if (out_px < 8'd160 && out_py < 7'd120) begin
                    cap_cre[int'(out_py) * 160 + int'(out_px)] = out_cre;
                    cap_cim[int'(out_py) * 160 + int'(out_px)] = out_cim;
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_stall = out_valid && !out_ready;
            prev_busy  = busy;
            p_px = out_px; p_py = out_py; p_cre = out_cre; p_cim = out_cim;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = ($urandom_range(0, 99) < rd_pct);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int diff;

        vt[0] = '{0,   0,   32'hFFE00000, 32'h00100000};
        vt[1] = '{159, 0,   32'h0007C000, 32'h00100000};
        vt[2] = '{0,   1,   32'hFFE00000, 32'h000FC000};
        vt[3] = '{0,   119, 32'hFFE00000, 32'hFFF24000};
        vt[4] = '{159, 119, 32'h0007C000, 32'hFFF24000};
        vt[5] = '{80,  60,  32'hFFF40000, 32'h00010000};

        clear_stats();
        repeat (3) tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_px", {24'd0, out_px}, 32'd0);
        check("rst_py", {25'd0, out_py}, 32'd0);
        check("rst_cre", out_cre, 32'd0);
        check("rst_cim", out_cim, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Frame A: full speed, start held high all frame, inputs changed mid-frame
        x0 = 32'hFFE00000; y0 = 32'h00100000; step = 32'h00004000;
        push_frame(x0, y0, step);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        check("A_first_valid", {31'd0, out_valid}, 32'd1);
        check("A_first_busy", {31'd0, busy}, 32'd1);
        check("A_first_px", {24'd0, out_px}, 32'd0);
        check("A_first_cre", out_cre, 32'hFFE00000);
        check("A_first_cim", out_cim, 32'h00100000);
        got = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            tick();
            if (i == 1000) begin
                x0 = 32'h7FFFC000; y0 = 32'h00000000; step = 32'h00008000;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("A_done_seen", {31'd0, got}, 32'd1);
        check("A_queue_empty", 32'(q.size()), 32'd0);
        out_ready = 1'b0;
        push_frame(32'h7FFFC000, 32'h00000000, 32'h00008000);
        tick();
        check("A_start_in_done_ignored_valid", {31'd0, out_valid}, 32'd0);
        check("A_start_in_done_ignored_busy", {31'd0, busy}, 32'd0);
        check("A_done_one_cycle", {31'd0, done}, 32'd0);
        tick();
        start = 1'b0;
        check("B_restart_valid", {31'd0, out_valid}, 32'd1);
        check("B_restart_px", {24'd0, out_px}, 32'd0);
        check("B_restart_cre", out_cre, 32'h7FFFC000);
        check("B_restart_cim", out_cim, 32'h00000000);
        frame_checks("A");
        apply_table("A");
        for (int i = 0; i < NPIX; i++) begin
            ref_cre[i] = cap_cre[i];
            ref_cim[i] = cap_cim[i];
        end
        clear_stats();

        // Frame B: hold-off stall, wrap-around values, reset mid-stall at (37,5)
        repeat (2) tick();
        check("B_stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("B_stall_hold_cre", out_cre, 32'h7FFFC000);
        out_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (hs_cnt >= 837) break;
        end
        out_ready = 1'b0;
        check("B_hs_at_stall", 32'(hs_cnt), 32'd837);
        check("B_stall_px", {24'd0, out_px}, 32'd37);
        check("B_stall_py", {25'd0, out_py}, 32'd5);
        check("B_stall_cre", out_cre, 32'h80124000);
        check("B_stall_cim", out_cim, 32'hFFFD8000);
        check("wrap_cre_1_0", cap_cre[1], 32'h80004000);
        check("B_scoreboard_errs", 32'(sb_err), 32'd0);
        repeat (2) tick();
        check("B_stall_still_px", {24'd0, out_px}, 32'd37);
        check("B_stall_still_cre", out_cre, 32'h80124000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_px", {24'd0, out_px}, 32'd0);
        check("midrst_py", {25'd0, out_py}, 32'd0);
        check("midrst_cre", out_cre, 32'd0);
        check("midrst_cim", out_cim, 32'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        clear_stats();
        tick();

        // Frame C: same setup as A under random back-pressure
        x0 = 32'hFFE00000; y0 = 32'h00100000; step = 32'h00004000;
        push_frame(x0, y0, step);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("C_restart_valid", {31'd0, out_valid}, 32'd1);
        check("C_restart_px", {24'd0, out_px}, 32'd0);
        check("C_restart_py", {25'd0, out_py}, 32'd0);
        check("C_restart_cre", out_cre, 32'hFFE00000);
        rd_pct = 30;
        rdy_mode = 1;
        got = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            tick();
            if (i == 4000) rd_pct = 90;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("C_done_seen", {31'd0, got}, 32'd1);
        rdy_mode = 0;
        repeat (2) tick();
        out_ready = 1'b0;
        frame_checks("C");
        check("C_queue_empty", 32'(q.size()), 32'd0);
        apply_table("C");
        diff = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (cap_cre[i] !== ref_cre[i] || cap_cim[i] !== ref_cim[i]) diff++;
        end
        check("C_vs_A_pixel_diffs", 32'(diff), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdbrot_pixel_scanner.md
# mdbrot_pixel_scanner

Upstream feeder for the Mandelbrot iteration core. On a start pulse it walks the 160×120 VGA raster in row-major order and emits one request per pixel: the screen coordinate plus the matching complex-plane point c = (c_re, c_im) in 32-bit fixed point. It uses a valid/ready handshake so the iteration core can stall it for as many cycles as a pixel needs. Coordinates are built by incremental addition only; there are no multipliers.

## Interface
Parameters:
- H_RES, 160, pixels per row
- V_RES, 120, rows per frame
- XW, 8, width of out_px
- YW, 7, width of out_py

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request; sampled only in IDLE
- x0  in  32  real part of pixel (0,0), left edge
- y0  in  32  imaginary part of pixel (0,0), top edge
- step  in  32  pixel pitch, positive, same format
- out_valid  out  1  request valid
- out_ready  in  1  core accepts the request
- out_px  out  XW  pixel column
- out_py  out  YW  pixel row
- out_cre  out  32  real part of c
- out_cim  out  32  imaginary part of c
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- Number format: two's-complement Q11.20 (32 bits, 20 fractional bits; 1.0 = 0x0010_0000).
- Adds and subtracts wrap modulo 2^32. There is no saturation.
- State machine: IDLE → SCAN → DONE → IDLE.
- IDLE behaviour:
  - busy=0 and out_valid=0.
  - When start=1, latch x0, y0 and step into internal registers.
  - Set px=0, py=0, cre=x0, cim=y0, then go to SCAN.
- SCAN behaviour:
  - out_valid=1 and busy=1.
  - Handshake fires when out_valid && out_ready.
  - On a handshake with px<H_RES-1: px+1, cre+step.
  - On a handshake with px=H_RES-1 and py<V_RES-1: px=0, cre=latched x0, py+1, cim−step.
  - On a handshake with px=H_RES-1 and py=V_RES-1: go to DONE.
- DONE behaviour: done=1, out_valid=0, busy=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE. Changes to x0, y0 or step during a frame have no effect.
- Exactly H_RES·V_RES handshakes occur per frame.

## Timing
- Reset values: out_valid=0, busy=0, done=0, out_px=0, out_py=0, out_cre=0, out_cim=0. State is IDLE.
- Latency:
  - start is sampled high at edge N.
  - out_valid=1 with pixel (0,0) is visible after edge N, so it is accepted at edge N+1 at the earliest.
- Throughput: one pixel per cycle while out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, all out_* stay stable. out_valid never drops without a handshake.
- done is high for the cycle after the final handshake. start may be asserted in the following cycle, once back in IDLE.
- start=1 in the same cycle as done is ignored.
- rst_n low at any point, including mid-frame or mid-stall, forces reset values immediately. No partial frame resumes.

## Structure
- Shared package mdbrot_pkg:
  - typedef fixed_t = logic signed [31:0]
  - FRAC_BITS=20
  - H_RES=160, V_RES=120
  - scan_state_t enum {IDLE, SCAN, DONE}
  - The iteration core imports the same fixed_t.
- Single module; no sub-module needed. Counters, accumulators and the FSM sit in one always_ff with a small next-state always_comb.

## Test plan
- Reset mid-frame: assert rst_n low at pixel (37,5) during a stall → all outputs 0 and busy=0 at once. A new start restarts the frame at (0,0) with cre=x0.
- Row sweep: x0=0xFFE00000 (−2.0), y0=0x00100000 (1.0), step=0x00004000 (2^-6), out_ready=1.
  - Pixel (0,0): cre=0xFFE00000.
  - Pixel (159,0): cre=0x0007C000.
  - Pixel (0,1): cre=0xFFE00000, cim=0x000FC000.
- Frame end, same setup:
  - Pixel (0,119): cim=0xFFF24000.
  - Exactly 19200 handshakes occur.
  - done pulses once, on the cycle after handshake 19200.
  - busy falls the cycle after that.
- Back-pressure: random out_ready with about 30% high → outputs stable whenever valid && !ready. Pixel sequence and values are identical to the no-stall run.
- Start ignored:
  - start held high throughout a frame, with x0 changed mid-frame → frame unchanged and no restart until IDLE.
  - start held through the done cycle → that start is ignored. start high the next cycle begins a new frame with pixel (0,0) and the new x0.
- Wrap-around: x0=0x7FFFC000, step=0x00008000 → cre at pixel (1,0)=0x80004000 (wraps, no saturation).
